cmap_ctrl: RTL and testbench

Run-time colormap controller for the spectrogram display path. It owns a double-banked 256-entry RGB palette RAM, streams 8-bit magnitude pixels through the active bank, and produces 24-bit false-colour pixels. A host port reloads the inactive bank, and bank swaps commit only at frame boundaries so no frame mixes two palettes. After reset it self-initialises the active bank to a grey ramp, so the display works before any host load.

---
 rtl/cmap_pkg.sv | 20 ++
 rtl/cmap_ram.sv | 53 +++++
 rtl/cmap_ctrl.sv | 127 ++++++++++++
 tb/tb_cmap_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cmap_pkg.sv
// Shared constants and types for the spectrogram colormap controller.
package cmap_pkg;

    localparam int CM_LGPAL   = 8;
    localparam int CM_ENTRY_W = 24;

    localparam logic [0:0] CM_INIT = 1'b0;
    localparam logic [0:0] CM_RUN  = 1'b1;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    function automatic logic [CM_ENTRY_W-1:0] cm_grey(input logic [7:0] k);
        return {k, k, k};
    endfunction

endpackage

// File: rtl/cmap_ram.sv
// Double-banked palette RAM: bank select is the address MSB on both the
// lookup port and the host write port; a fill port seeds bank 0 after reset.
module cmap_ram
    import cmap_pkg::*;
#(
    parameter int LGPAL = CM_LGPAL,
    parameter int DW    = CM_ENTRY_W
) (
    input  logic             i_clk,
    input  logic             i_areset_n,
    input  logic             i_rd_en,
    input  logic [LGPAL:0]   i_rd_addr,
    output logic [DW-1:0]    o_rd_data,
    input  logic             i_wr,
    input  logic [LGPAL:0]   i_wr_addr,
    input  logic [DW-1:0]    i_wr_data,
    input  logic             i_fill,
    input  logic [LGPAL-1:0] i_fill_addr,
    input  logic [DW-1:0]    i_fill_data
);

    localparam int DEPTH = 2 ** LGPAL;

    logic [DW-1:0] r_bank0 [DEPTH];
    logic [DW-1:0] r_bank1 [DEPTH];
    logic [DW-1:0] r_rd_data;

    // The fill port only runs during INIT, when bank 0 is active and the host
    // port can only reach bank 1, so the two writers never meet.
    // NOTE: palette arrays carry no reset; clearing them would turn block RAM into flops.
    always_ff @(posedge i_clk) begin
        if (i_wr) begin
            if (i_wr_addr[LGPAL]) r_bank1[i_wr_addr[LGPAL-1:0]] <= i_wr_data;
            else                  r_bank0[i_wr_addr[LGPAL-1:0]] <= i_wr_data;
        end
        if (i_fill) begin
            r_bank0[i_fill_addr] <= i_fill_data;
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= i_rd_addr[LGPAL] ? r_bank1[i_rd_addr[LGPAL-1:0]]
                                          : r_bank0[i_rd_addr[LGPAL-1:0]];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/cmap_ctrl.sv
// Colormap controller: self-initialising grey ramp, pixel lookup pipeline,
// frame tracking and frame-aligned palette bank swapping.
module cmap_ctrl
    import cmap_pkg::*;
#(
    parameter int LGPAL = CM_LGPAL
) (
    input  logic             i_clk,
    input  logic             i_areset_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [LGPAL-1:0] i_pixel,
    input  logic             i_last,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [7:0]       o_r,
    output logic [7:0]       o_g,
    output logic [7:0]       o_b,
    output logic             o_last,
    input  logic             i_wr,
    input  logic [LGPAL-1:0] i_wr_addr,
    input  logic [23:0]      i_wr_data,
    input  logic             i_swap,
    output logic             o_bank,
    output logic             o_swap_pending,
    output logic             o_init_done
);

    localparam logic [LGPAL-1:0] LAST_IDX = '1;

    logic [0:0]       r_state;
    logic [LGPAL-1:0] r_init_cnt;
    logic             r_init_done;
    logic             r_valid;
    logic             r_last;
    logic             r_bank;
    logic             r_swap_pending;
    logic             r_in_frame;

    logic             w_run;
    logic             w_ready;
    logic             w_accept;
    logic             w_pend_eff;
    logic             w_commit;
    logic [23:0]      w_rd_data;
    rgb_t             w_rgb;

    assign w_run      = (r_state == CM_RUN);
    assign w_ready    = w_run && (!r_valid || i_ready);
    assign w_accept   = i_valid && w_ready;
    assign w_pend_eff = r_swap_pending || i_swap;

    // Commit either on the frame's last pixel, or when idle between frames.
    // A non-last accept blocks the idle path so a frame never straddles banks.
    assign w_commit = (w_accept && i_last && w_pend_eff) ||
                      (r_swap_pending && !r_in_frame && !w_accept && w_run);

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_state     <= CM_INIT;
            r_init_cnt  <= '0;
            r_init_done <= 1'b0;
        end else if (r_state == CM_INIT) begin
            r_init_cnt <= r_init_cnt + 1'b1;
            if (r_init_cnt == LAST_IDX) begin
                r_state     <= CM_RUN;
                r_init_done <= 1'b1;
            end
        end
    end

    // Output stage advances whenever downstream can take a word.
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (w_ready) begin
            r_valid <= w_accept;
            if (w_accept) r_last <= i_last;
        end
    end

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_in_frame     <= 1'b0;
            r_swap_pending <= 1'b0;
            r_bank         <= 1'b0;
        end else begin
            if (w_accept) r_in_frame <= !i_last;
            if (w_commit) begin
                r_bank         <= !r_bank;
                r_swap_pending <= 1'b0;
            end else if (i_swap) begin
                r_swap_pending <= 1'b1;
            end
        end
    end

    cmap_ram #(
        .LGPAL (LGPAL),
        .DW    (CM_ENTRY_W)
    ) u_ram (
        .i_clk       (i_clk),
        .i_areset_n  (i_areset_n),
        .i_rd_en     (w_accept),
        .i_rd_addr   ({r_bank, i_pixel}),
        .o_rd_data   (w_rd_data),
        .i_wr        (i_wr),
        .i_wr_addr   ({!r_bank, i_wr_addr}),
        .i_wr_data   (i_wr_data),
        .i_fill      (!w_run),
        .i_fill_addr (r_init_cnt),
        .i_fill_data (cm_grey(8'(r_init_cnt)))
    );

    assign w_rgb          = w_rd_data;
    assign o_r            = w_rgb.r;
    assign o_g            = w_rgb.g;
    assign o_b            = w_rgb.b;
    assign o_ready        = w_ready;
    assign o_valid        = r_valid;
    assign o_last         = r_last;
    assign o_bank         = r_bank;
    assign o_swap_pending = r_swap_pending;
    assign o_init_done    = r_init_done;

endmodule

// File: tb/tb_cmap_ctrl.sv
// Directed bench for cmap_ctrl: vector table for streaming, hand sequences
// for init timing, bank swaps and mid-frame reset.
module tb_cmap_ctrl;

    logic        i_clk = 1'b0;
    logic        i_areset_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [7:0]  i_pixel = '0;
    logic        i_last = 1'b0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [7:0]  o_r, o_g, o_b;
    logic        o_last;
    logic        i_wr = 1'b0;
    logic [7:0]  i_wr_addr = '0;
    logic [23:0] i_wr_data = '0;
    logic        i_swap = 1'b0;
    logic        o_bank;
    logic        o_swap_pending;
    logic        o_init_done;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        valid;
        logic [7:0]  pixel;
        logic        last;
        logic        dready;
        logic        swap;
        logic        e_ready;
        logic        e_valid;
        logic [23:0] e_rgb;
        logic        e_last;
        logic        e_bank;
        logic        e_pend;
    } vec_t;

    vec_t stream [20];

    always #5 i_clk = ~i_clk;

    cmap_ctrl #(.LGPAL(8)) dut (
        .i_clk          (i_clk),
        .i_areset_n     (i_areset_n),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .i_pixel        (i_pixel),
        .i_last         (i_last),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_r            (o_r),
        .o_g            (o_g),
        .o_b            (o_b),
        .o_last         (o_last),
        .i_wr           (i_wr),
        .i_wr_addr      (i_wr_addr),
        .i_wr_data      (i_wr_data),
        .i_swap         (i_swap),
        .o_bank         (o_bank),
        .o_swap_pending (o_swap_pending),
        .o_init_done    (o_init_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [7:0] p, input logic l,
                                input logic r, input logic sw, input logic er,
                                input logic ev, input logic [23:0] rgb, input logic el,
                                input logic eb, input logic ep);
        vec_t x;
        x.valid = v;   x.pixel = p;   x.last = l;    x.dready = r;  x.swap = sw;
        x.e_ready = er; x.e_valid = ev; x.e_rgb = rgb; x.e_last = el;
        x.e_bank = eb; x.e_pend = ep;
        return x;
    endfunction

    // Entered and left just after a rising edge.
    task automatic apply(input vec_t v, input string tag);
        i_valid = v.valid;
        i_pixel = v.pixel;
        i_last  = v.last;
        i_ready = v.dready;
        i_swap  = v.swap;
        #1;
        check({tag, ".ready"}, 32'(o_ready), 32'(v.e_ready));
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_swap  = 1'b0;
        check({tag, ".valid"}, 32'(o_valid), 32'(v.e_valid));
        if (v.e_valid) begin
            check({tag, ".rgb"}, 32'({o_r, o_g, o_b}), 32'(v.e_rgb));
            check({tag, ".last"}, 32'(o_last), 32'(v.e_last));
        end
        check({tag, ".bank"}, 32'(o_bank), 32'(v.e_bank));
        check({tag, ".pend"}, 32'(o_swap_pending), 32'(v.e_pend));
    endtask

    task automatic host_write(input logic [7:0] addr, input logic [23:0] data);
        i_wr      = 1'b1;
        i_wr_addr = addr;
        i_wr_data = data;
        @(posedge i_clk);
        #1;
        i_wr = 1'b0;
    endtask

    // Counts rising edges until o_ready rises; -1 if the budget runs out.
    task automatic wait_init(output int n);
        n = -1;
        for (int k = 1; k <= 400; k++) begin
            @(posedge i_clk);
            #1;
            if (o_ready) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".ready"}, 32'(o_ready), 32'd0);
        check({tag, ".valid"}, 32'(o_valid), 32'd0);
        check({tag, ".rgb"}, 32'({o_r, o_g, o_b}), 32'd0);
        check({tag, ".last"}, 32'(o_last), 32'd0);
        check({tag, ".bank"}, 32'(o_bank), 32'd0);
        check({tag, ".pend"}, 32'(o_swap_pending), 32'd0);
        check({tag, ".init_done"}, 32'(o_init_done), 32'd0);
    endtask

    initial begin
        int n;
        logic [7:0] p;

        // Ramp 0..15 with a 3-cycle downstream stall while pixel 5 is on the output.
        for (int i = 0; i < 6; i++) begin
            p = 8'(i);
            stream[i] = mk(1, p, 0, 1, 0, 1, 1, {p, p, p}, 0, 0, 0);
        end
        for (int i = 6; i < 9; i++)
            stream[i] = mk(1, 8'h06, 0, 0, 0, 0, 1, 24'h050505, 0, 0, 0);
        for (int i = 9; i < 19; i++) begin
            p = 8'(i - 3);
            stream[i] = mk(1, p, p == 8'd15, 1, 0, 1, 1, {p, p, p}, p == 8'd15, 0, 0);
        end
        stream[19] = mk(0, 8'h00, 0, 1, 0, 1, 0, 24'h0, 0, 0, 0);

        #12;
        check_reset_values("por");
        @(negedge i_clk);
        i_areset_n = 1'b1;
        wait_init(n);
        check("init_cycles", 32'(n), 32'd256);
        check("init_done", 32'(o_init_done), 32'd1);

        apply(mk(1, 8'h80, 1, 1, 0, 1, 1, 24'h808080, 1, 0, 0), "first_px");

        for (int i = 0; i < 20; i++)
            apply(stream[i], $sformatf("stream%0d", i));

        // Mid-frame swap: bank 1 entry 5 only becomes visible next frame.
        host_write(8'h05, 24'hFF0000);
        apply(mk(1, 8'h05, 0, 1, 0, 1, 1, 24'h050505, 0, 0, 0), "mid_a");
        apply(mk(1, 8'h05, 0, 1, 1, 1, 1, 24'h050505, 0, 0, 1), "mid_b");
        apply(mk(1, 8'h05, 0, 1, 0, 1, 1, 24'h050505, 0, 0, 1), "mid_c");
        apply(mk(1, 8'h05, 1, 1, 0, 1, 1, 24'h050505, 1, 1, 0), "mid_last");
        apply(mk(1, 8'h05, 0, 1, 0, 1, 1, 24'hFF0000, 0, 1, 0), "next_a");
        apply(mk(1, 8'h05, 1, 1, 0, 1, 1, 24'hFF0000, 1, 1, 0), "next_last");
        apply(mk(0, 8'h00, 0, 1, 0, 1, 0, 24'h0, 0, 1, 0), "gap");

        // Idle swap: pending for one cycle, then commit.
        apply(mk(0, 8'h00, 0, 1, 1, 1, 0, 24'h0, 0, 1, 1), "idle_req");
        apply(mk(0, 8'h00, 0, 1, 0, 1, 0, 24'h0, 0, 0, 0), "idle_commit");

        // Swap pulse coincident with the last pixel.
        apply(mk(1, 8'h20, 0, 1, 0, 1, 1, 24'h202020, 0, 0, 0), "coin_a");
        apply(mk(1, 8'h21, 1, 1, 1, 1, 1, 24'h212121, 1, 1, 0), "coin_last");
        apply(mk(1, 8'h05, 1, 1, 0, 1, 1, 24'hFF0000, 1, 1, 0), "coin_new");
        apply(mk(0, 8'h00, 0, 1, 0, 1, 0, 24'h0, 0, 1, 0), "coin_gap");

        // Reset in the middle of a frame with a pixel in flight and a swap pending.
        apply(mk(1, 8'h05, 0, 1, 1, 1, 1, 24'hFF0000, 0, 1, 1), "pre_rst");
        #2;
        i_areset_n = 1'b0;
        #1;
        check_reset_values("mid_rst");
        repeat (2) @(negedge i_clk);
        i_areset_n = 1'b1;
        wait_init(n);
        check("reinit_cycles", 32'(n), 32'd256);
        apply(mk(1, 8'h10, 1, 1, 0, 1, 1, 24'h101010, 1, 0, 0), "post_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
